// File: rtl/keystream_hex_display_pkg.sv
// Shared types and constants for the keystream hex display.
package keystream_hex_display_pkg;

  // Display FSM states.
  typedef enum logic [1:0] {
    ST_BLANK   = 2'd0,  // no word received since reset
    ST_SHOW    = 2'd1,  // showing the digits of cur
    ST_STARVED = 2'd2   // word finished and no follow-up word ready
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Segment patterns {g,f,e,d,c,b,a} for hex digits. Entry [n] is digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/keystream_hex_display_if.sv
// Keystream word handshake between the ChaCha20 core and the display.
//
// Handshake: a word transfers on a rising clk edge exactly when word_valid and
// word_ready are both high. word is only meaningful in that cycle. The
// display's word_ready depends on registers and rst only, never on word_valid.
interface keystream_hex_display_if;
  logic        word_valid;
  logic [31:0] word;
  logic        word_ready;

  modport master (output word_valid, output word, input word_ready);
  modport slave  (input word_valid, input word, output word_ready);
endinterface

// File: rtl/keystream_hex_display_hex_to_7seg.sv
// Combinational hex nibble to 7-segment pattern lookup.
module hex_to_7seg
  import keystream_hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/keystream_hex_display.sv
// Shows 32-bit keystream words as 8 hex digits on a 7-segment display,
// MSB nibble first, MAX_COUNT cycles per digit, with one word of buffering.
module keystream_hex_display
  import keystream_hex_display_pkg::*;
#(
  parameter int MAX_COUNT = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  keystream_hex_display_if.slave        up,
  output logic [6:0]                    segments,
  output logic                          seg_dp,
  output disp_state_e                   dbg_state_o
);

  localparam int DW = $clog2(MAX_COUNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(MAX_COUNT - 1);

  disp_state_e   state_q, state_d;
  logic [31:0]   cur_q, cur_d;
  logic [31:0]   pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [2:0]    nib_q, nib_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          hs;
  logic          last_dwell;
  logic          word_end;
  logic [3:0]    nib_sel;
  logic [6:0]    hex_seg;

  assign up.word_ready = !pend_full_q && !rst;
  assign hs            = up.word_valid && up.word_ready;
  assign last_dwell    = (dwell_q == DWELL_LAST);
  assign word_end      = last_dwell && (nib_q == 3'd0);

  // Next-state for buffer, counters and FSM.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    nib_d       = nib_q;
    dwell_d     = dwell_q;
    case (state_q)
      ST_BLANK, ST_STARVED: begin
        // Nothing on display to wait for: load straight into cur.
        if (hs) begin
          cur_d   = up.word;
          nib_d   = 3'd7;
          dwell_d = '0;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (last_dwell) begin
          dwell_d = '0;
          nib_d   = nib_q - 3'd1;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
        if (word_end) begin
          // Chain the next word without a gap when one is available.
          if (pend_full_q) begin
            cur_d       = pend_q;
            pend_full_d = 1'b0;
            nib_d       = 3'd7;
          end else if (hs) begin
            cur_d = up.word;
            nib_d = 3'd7;
          end else begin
            state_d = ST_STARVED;
          end
        end else if (hs) begin
          // ready is only high with pend empty, so this never overwrites.
          pend_d      = up.word;
          pend_full_d = 1'b1;
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Segment pattern for the digit that will be on display next cycle.
  assign nib_sel = cur_d[{nib_d, 2'b00} +: 4];

  hex_to_7seg u_hex_to_7seg (
    .nibble_i (nib_sel),
    .seg_o    (hex_seg)
  );

  // Output pattern and decimal point derived from next state.
  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    case (state_d)
      ST_SHOW: begin
        seg_d = hex_seg;
        dp_d  = (nib_d == 3'd7);
      end
      ST_STARVED: seg_d = SEG_DASH;
      default:    seg_d = SEG_BLANK;
    endcase
  end

  // State register with synchronous reset; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BLANK;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      nib_q       <= 3'd7;
      dwell_q     <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      nib_q       <= nib_d;
      dwell_q     <= dwell_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign segments    = seg_q;
  assign seg_dp      = dp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keystream_hex_display.sv
// Directed bench for keystream_hex_display with MAX_COUNT=4.
module tb_keystream_hex_display;
  import keystream_hex_display_pkg::*;

  localparam int MC = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  keystream_hex_display_if ks_if ();
  logic [6:0]  segments;
  logic        seg_dp;
  disp_state_e dbg_state;

  keystream_hex_display #(.MAX_COUNT(MC)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (ks_if),
    .segments    (segments),
    .seg_dp      (seg_dp),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Hand-entered segment reference, digit 0..F.
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: present a word at a falling edge once ready; accepted at next rise.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!ks_if.word_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, ks_if.word_ready}, 32'd1);
    ks_if.word_valid = 1'b1;
    ks_if.word       = w;
  endtask

  // Check display cycles start..31 of word w; optionally offer nw on the last one.
  task automatic check_word(input logic [31:0] w, input int start,
                            input bit offer, input logic [31:0] nw);
    int digit;
    logic [3:0] nibble;
    for (int i = start; i < 8 * MC; i++) begin
      @(negedge clk);
      digit  = 7 - i / MC;
      nibble = w[digit*4 +: 4];
      chk($sformatf("seg w=%h i=%0d", w, i), {25'd0, segments}, {25'd0, seg_ref(nibble)});
      chk($sformatf("dp w=%h i=%0d", w, i), {31'd0, seg_dp}, (i < MC) ? 32'd1 : 32'd0);
      if (i == 0) begin
        ks_if.word_valid = 1'b0;
        ks_if.word       = 'x;
      end
      if (offer && i == 8 * MC - 1) begin
        ks_if.word_valid = 1'b1;
        ks_if.word       = nw;
      end
    end
  endtask

  task automatic check_dash(input string tag);
    @(negedge clk);
    chk({tag, "_seg"}, {25'd0, segments}, 32'h40);
    chk({tag, "_dp"}, {31'd0, seg_dp}, 32'd0);
    chk({tag, "_ready"}, {31'd0, ks_if.word_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    ks_if.word_valid = 1'b0;
    ks_if.word       = '0;

    // Reset state and idle
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ks_if.word_ready}, 32'd0);
    chk("rst_seg", {25'd0, segments}, 32'h00);
    chk("rst_dp", {31'd0, seg_dp}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ks_if.word_ready}, 32'd1);
    repeat (20) @(negedge clk);
    chk("idle_seg", {25'd0, segments}, 32'h00);
    chk("idle_dp", {31'd0, seg_dp}, 32'd0);
    chk("idle_ready", {31'd0, ks_if.word_ready}, 32'd1);
    chk("idle_state", {30'd0, dbg_state}, {30'd0, ST_BLANK});

    // Single word then starve
    send_word(32'h0123ABCD);
    check_word(32'h0123ABCD, 0, 1'b0, 32'h0);
    check_dash("starve1");

    // Back-to-back words: second goes to the pending buffer
    @(negedge clk);
    chk("starve1b_seg", {25'd0, segments}, 32'h40);
    ks_if.word_valid = 1'b1;
    ks_if.word       = 32'hFFFFFFFF;
    @(negedge clk);
    chk("b2b_first_seg", {25'd0, segments}, 32'h71);
    chk("b2b_first_dp", {31'd0, seg_dp}, 32'd1);
    chk("b2b_first_ready", {31'd0, ks_if.word_ready}, 32'd1);
    ks_if.word = 32'h00000000;
    @(negedge clk);
    chk("b2b_pend_ready", {31'd0, ks_if.word_ready}, 32'd0);
    chk("b2b_second_seg", {25'd0, segments}, 32'h71);
    ks_if.word_valid = 1'b0;
    ks_if.word       = 'x;
    check_word(32'hFFFFFFFF, 2, 1'b0, 32'h0);
    check_word(32'h00000000, 0, 1'b0, 32'h0);
    check_dash("starve2");

    // Word offered on the last dwell cycle bypasses into cur without a gap
    send_word(32'h89ABCDEF);
    check_word(32'h89ABCDEF, 0, 1'b1, 32'h45670123);
    check_word(32'h45670123, 0, 1'b0, 32'h0);
    check_dash("starve3");

    // Reset mid-word with pending word full
    send_word(32'h11111111);
    @(negedge clk);
    chk("rstmid_seg", {25'd0, segments}, 32'h06);
    ks_if.word = 32'h22222222;
    @(negedge clk);
    chk("rstmid_pend_ready", {31'd0, ks_if.word_ready}, 32'd0);
    ks_if.word_valid = 1'b0;
    ks_if.word       = 'x;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_in_seg", {25'd0, segments}, 32'h00);
    chk("rstmid_in_dp", {31'd0, seg_dp}, 32'd0);
    chk("rstmid_in_ready", {31'd0, ks_if.word_ready}, 32'd0);
    ks_if.word_valid = 1'b1;
    ks_if.word       = 32'h33333333;
    @(negedge clk);
    chk("rstmid_valid_ignored", {25'd0, segments}, 32'h00);
    rst              = 1'b0;
    ks_if.word_valid = 1'b0;
    ks_if.word       = 'x;
    @(negedge clk);
    chk("rstmid_after_seg", {25'd0, segments}, 32'h00);
    chk("rstmid_after_ready", {31'd0, ks_if.word_ready}, 32'd1);
    chk("rstmid_after_state", {30'd0, dbg_state}, {30'd0, ST_BLANK});
    repeat (40) @(negedge clk);
    chk("rstmid_idle_seg", {25'd0, segments}, 32'h00);
    chk("rstmid_idle_ready", {31'd0, ks_if.word_ready}, 32'd1);

    // Clean restart after reset
    send_word(32'hFEDCBA98);
    check_word(32'hFEDCBA98, 0, 1'b0, 32'h0);
    check_dash("starve4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
